operand_read_stage: RTL and testbench

- Source-operand fetch stage for the EV22 datapath; the read-side counterpart of the writeback destination decoder.
- Takes the 6-bit A/B source fields, selects the two operands from the flattened register-bank outputs, and registers them toward the ALU through a valid/ready pipeline slot.
- Forwards same-cycle writebacks using the writeback encoding: 0–61 write that register, 61 and 62 both write reg 61 (62 = memory load), 63 writes nothing.

---
 rtl/ev22_pkg.sv | 22 ++
 rtl/operand_resolve.sv | 34 +++
 rtl/operand_read_stage.sv | 91 +++++++++
 tb/tb_operand_read_stage.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ev22_pkg.sv
// Shared EV22 datapath constants: field widths, source/writeback codes and the
// write-hit rule used by operand forwarding.
package ev22_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned SEL_W    = 6;
  localparam int unsigned NUM_REGS = 62;

  localparam logic [SEL_W-1:0] SRC_IMM  = SEL_W'(62);
  localparam logic [SEL_W-1:0] SRC_ZERO = SEL_W'(63);
  localparam logic [SEL_W-1:0] WB_LOAD  = SEL_W'(62);
  localparam logic [SEL_W-1:0] WB_NONE  = SEL_W'(63);
  localparam logic [SEL_W-1:0] REG_LINK = SEL_W'(61);

  // A memory load (WB_LOAD) lands in REG_LINK; WB_NONE can never match a register index.
  function automatic logic wb_hits(input logic [SEL_W-1:0] sel,
                                   input logic [SEL_W-1:0] wb_c);
    return ((sel <= REG_LINK) && (sel == wb_c)) ||
           ((sel == REG_LINK) && (wb_c == WB_LOAD));
  endfunction

endpackage

// File: rtl/operand_resolve.sv
// Resolves one source selector to an operand value: immediate, zero,
// same-cycle writeback forward, or the register bank slice.
module operand_resolve
  import ev22_pkg::*;
(
  input  logic [SEL_W-1:0]           sel,
  input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
  input  logic [DATA_W-1:0]          imm,
  input  logic [SEL_W-1:0]           wb_c,
  input  logic [DATA_W-1:0]          wb_data,
  output logic [DATA_W-1:0]          value_c,
  output logic                       hit_c
);

  logic [DATA_W-1:0] w_reg;

  // Constant-index mux keeps the 62/63 codes from ever addressing past the bank.
  always_comb begin
    w_reg = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (sel == SEL_W'(i)) w_reg = regs_flat[i*DATA_W +: DATA_W];
    end
  end

  assign hit_c = wb_hits(sel, wb_c);

  always_comb begin
    value_c = w_reg;
    if (sel == SRC_IMM)       value_c = imm;
    else if (sel == SRC_ZERO) value_c = '0;
    else if (hit_c)           value_c = wb_data;
  end

endmodule

// File: rtl/operand_read_stage.sv
// EV22 source-operand fetch stage: resolves A/B with writeback forwarding and
// holds them in a single valid/ready slot toward the ALU.
module operand_read_stage
  import ev22_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SEL_W-1:0]           a_sel,
  input  logic [SEL_W-1:0]           b_sel,
  input  logic [DATA_W-1:0]          imm,
  input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
  input  logic [SEL_W-1:0]           wb_c,
  input  logic [DATA_W-1:0]          wb_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          bus_a,
  output logic [DATA_W-1:0]          bus_b
);

  logic              r_out_valid;
  logic [DATA_W-1:0] r_bus_a;
  logic [DATA_W-1:0] r_bus_b;
  logic [SEL_W-1:0]  r_held_a;
  logic [SEL_W-1:0]  r_held_b;

  logic              w_accept;
  logic              w_stall;
  logic [SEL_W-1:0]  w_sel_a;
  logic [SEL_W-1:0]  w_sel_b;
  logic [DATA_W-1:0] w_val_a;
  logic [DATA_W-1:0] w_val_b;
  logic              w_hit_a;
  logic              w_hit_b;

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_stall  = r_out_valid && !out_ready;

  // While stalled the resolvers watch the held selectors so their hit flags drive the refresh.
  assign w_sel_a = w_stall ? r_held_a : a_sel;
  assign w_sel_b = w_stall ? r_held_b : b_sel;

  operand_resolve u_resolve_a (
    .sel       (w_sel_a),
    .regs_flat (regs_flat),
    .imm       (imm),
    .wb_c      (wb_c),
    .wb_data   (wb_data),
    .value_c   (w_val_a),
    .hit_c     (w_hit_a)
  );

  operand_resolve u_resolve_b (
    .sel       (w_sel_b),
    .regs_flat (regs_flat),
    .imm       (imm),
    .wb_c      (wb_c),
    .wb_data   (wb_data),
    .value_c   (w_val_b),
    .hit_c     (w_hit_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_bus_a     <= '0;
      r_bus_b     <= '0;
      r_held_a    <= SRC_ZERO;
      r_held_b    <= SRC_ZERO;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_bus_a     <= w_val_a;
      r_bus_b     <= w_val_b;
      r_held_a    <= a_sel;
      r_held_b    <= b_sel;
    end else if (w_stall) begin
      // Immediate/zero selectors never hit, so captured imm values stay put.
      if (w_hit_a) r_bus_a <= w_val_a;
      if (w_hit_b) r_bus_b <= w_val_b;
    end else if (r_out_valid) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign bus_a     = r_bus_a;
  assign bus_b     = r_bus_b;

endmodule

// File: tb/tb_operand_read_stage.sv
// Randomized self-checking bench for operand_read_stage against a
// transaction-level model of the operand slot.
module tb_operand_read_stage;
  import ev22_pkg::*;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       in_valid;
  logic                       in_ready;
  logic [SEL_W-1:0]           a_sel;
  logic [SEL_W-1:0]           b_sel;
  logic [DATA_W-1:0]          imm;
  logic [NUM_REGS*DATA_W-1:0] regs_flat;
  logic [SEL_W-1:0]           wb_c;
  logic [DATA_W-1:0]          wb_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [DATA_W-1:0]          bus_a;
  logic [DATA_W-1:0]          bus_b;

  logic [DATA_W-1:0] regs [NUM_REGS];

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the slot: whether a pair is held, its values and its source codes.
  bit               m_valid;
  logic [15:0]      m_a;
  logic [15:0]      m_b;
  logic [5:0]       m_sa;
  logic [5:0]       m_sb;

  always #5 clk = ~clk;

  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) regs_flat[i*16 +: 16] = regs[i];
  end

  operand_read_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_sel     (a_sel),
    .b_sel     (b_sel),
    .imm       (imm),
    .regs_flat (regs_flat),
    .wb_c      (wb_c),
    .wb_data   (wb_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bus_a     (bus_a),
    .bus_b     (bus_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Register s is being written this cycle (a load writes register 61).
  function automatic bit written(input logic [5:0] s);
    if (s > 6'd61) return 1'b0;
    if (wb_c == s) return 1'b1;
    return (s == 6'd61) && (wb_c == 6'd62);
  endfunction

  function automatic logic [15:0] operand(input logic [5:0] s);
    if (s == 6'd62) return imm;
    if (s == 6'd63) return 16'h0000;
    if (written(s)) return wb_data;
    return regs[s];
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_a = 16'h0;
    m_b = 16'h0;
    m_sa = 6'd63;
    m_sb = 6'd63;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, ".bus_a"}, 32'(bus_a), 32'(m_a));
    chk({tag, ".bus_b"}, 32'(bus_b), 32'(m_b));
  endtask

  // One clock: inputs already driven; predict, clock, compare.
  task automatic tick(input string tag);
    bit          take;
    bit          hold;
    logic [15:0] na, nb;
    #1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(!m_valid || out_ready));
    take = in_valid && (!m_valid || out_ready);
    hold = m_valid && !out_ready;
    na = m_a;
    nb = m_b;
    if (take) begin
      na = operand(a_sel);
      nb = operand(b_sel);
    end else if (hold) begin
      if (written(m_sa)) na = wb_data;
      if (written(m_sb)) nb = wb_data;
    end
    @(posedge clk);
    #1;
    if (take) begin
      m_sa = a_sel;
      m_sb = b_sel;
      m_valid = 1'b1;
    end else if (!hold) begin
      m_valid = 1'b0;
    end
    m_a = na;
    m_b = nb;
    check_outputs(tag);
  endtask

  task automatic drive(input bit v, input logic [5:0] sa, input logic [5:0] sb,
                       input logic [15:0] im, input logic [5:0] wc,
                       input logic [15:0] wd, input bit rdy);
    in_valid = v;
    a_sel = sa;
    b_sel = sb;
    imm = im;
    wb_c = wc;
    wb_data = wd;
    out_ready = rdy;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < int'(NUM_REGS); i++) regs[i] = 16'(i * 16'h0101);
    drive(1'b0, 6'd63, 6'd63, 16'h0, 6'd63, 16'h0, 1'b1);
    model_reset();
    #2;
    check_outputs("reset");
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Plain register read plus zero source.
    regs[5] = 16'h1234;
    drive(1'b1, 6'd5, 6'd63, 16'hAAAA, 6'd63, 16'h0, 1'b1);
    tick("t1");
    chk("t1.a_const", 32'(bus_a), 32'h1234);
    chk("t1.b_const", 32'(bus_b), 32'h0000);

    // Forward over the stale register value, immediate on B.
    regs[10] = 16'h0001;
    drive(1'b1, 6'd10, 6'd62, 16'h00FF, 6'd10, 16'hBEEF, 1'b1);
    tick("t2");
    chk("t2.a_const", 32'(bus_a), 32'hBEEF);
    chk("t2.b_const", 32'(bus_b), 32'h00FF);

    // Register 61 written by load code, by its own code, and not at all.
    regs[61] = 16'h6161;
    drive(1'b1, 6'd61, 6'd61, 16'h0, 6'd62, 16'h5A5A, 1'b1);
    tick("t3load");
    chk("t3load.a_const", 32'(bus_a), 32'h5A5A);
    chk("t3load.b_const", 32'(bus_b), 32'h5A5A);
    drive(1'b1, 6'd61, 6'd61, 16'h0, 6'd61, 16'h5A5A, 1'b1);
    tick("t3reg");
    chk("t3reg.a_const", 32'(bus_a), 32'h5A5A);
    drive(1'b1, 6'd61, 6'd61, 16'h0, 6'd60, 16'h5A5A, 1'b1);
    tick("t3miss");
    chk("t3miss.a_const", 32'(bus_a), 32'h6161);
    chk("t3miss.b_const", 32'(bus_b), 32'h6161);

    // Stall with a writeback to the held register, then drain.
    regs[3] = 16'h0003;
    drive(1'b1, 6'd3, 6'd62, 16'h0777, 6'd63, 16'h0, 1'b1);
    tick("t4acc");
    drive(1'b1, 6'd4, 6'd4, 16'h1111, 6'd63, 16'hDEAD, 1'b0);
    tick("t4s1");
    drive(1'b1, 6'd4, 6'd4, 16'h2222, 6'd3, 16'h0042, 1'b0);
    tick("t4s2");
    chk("t4s2.a_const", 32'(bus_a), 32'h0042);
    chk("t4s2.b_const", 32'(bus_b), 32'h0777);
    drive(1'b1, 6'd4, 6'd4, 16'h3333, 6'd62, 16'hFFFF, 1'b0);
    tick("t4s3");
    chk("t4s3.a_const", 32'(bus_a), 32'h0042);
    drive(1'b0, 6'd4, 6'd4, 16'h0, 6'd63, 16'h0, 1'b1);
    tick("t4drain");
    chk("t4drain.valid_const", 32'(out_valid), 32'd0);

    // Full-throughput streaming.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 6'(i), 6'(7 - i), 16'h0, 6'd63, 16'h0, 1'b1);
      tick("t5");
      chk("t5.ready_const", 32'(in_ready), 32'd1);
      chk("t5.a_const", 32'(bus_a), 32'(regs[i]));
    end

    // Reset in the middle of a stall, between clock edges.
    drive(1'b1, 6'd9, 6'd62, 16'h4444, 6'd63, 16'h0, 1'b0);
    tick("t6stall");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("t6rst");
    chk("t6rst.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 6'd63, 6'd63, 16'h0, 6'd63, 16'h0, 1'b0);
    tick("t6post");

    // Random traffic, biased toward forwarding and the 61/62 aliasing corner.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] = 16'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      a_sel     = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(60, 63)) : 6'($urandom);
      b_sel     = ($urandom_range(0, 3) == 0) ? a_sel : 6'($urandom);
      imm       = 16'($urandom);
      wb_data   = 16'($urandom);
      case ($urandom_range(0, 4))
        0:       wb_c = a_sel;
        1:       wb_c = m_sa;
        2:       wb_c = 6'($urandom_range(61, 63));
        default: wb_c = 6'($urandom);
      endcase
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
